// File: rtl/dac_tx_pkg.sv
// Shared definitions for the serial DAC transmitter: FSM states, status codes, frame layout.
package dac_tx_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_LATCH_LO = 3'd2,
        ST_LATCH_HI = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic [7:0] {
        STAT_IDLE  = 8'h00,
        STAT_SHIFT = 8'h02,
        STAT_SENT  = 8'h03,
        STAT_DONE  = 8'h05
    } status_e;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Command nibble occupies the top of the frame, sample the low 12 bits.
    function automatic frame_t build_frame(input logic [3:0] ctrl, input logic [11:0] smp);
        return {ctrl, smp};
    endfunction

endpackage

// File: rtl/clk_tick_div.sv
// Tick divider: one-clk tick every CLK_DIV clk cycles while en is high; clr restarts the count.
// First tick lands CLK_DIV cycles after clr; no flow control, the counter free-runs while enabled.
module clk_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/dac_tx.sv
// Serial DAC transmitter: sends {control, data_dac} MSB first under cs, then strobes ldac for one tick.
// Frame takes 34 ticks plus the DONE clk; start_tx is honoured only in IDLE and dropped while busy.
module dac_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_tx,
    input  logic [3:0]  control,
    input  logic [11:0] data_dac,
    output logic        busy,
    output logic        done,
    output logic [7:0]  status,
    output logic        cs,
    output logic        sclk,
    output logic        data_out,
    output logic        ldac
);

    import dac_tx_pkg::*;

    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    state_e            state_q,    state_d;
    status_e           status_q,   status_d;
    frame_t            shift_q,    shift_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              cs_q,       cs_d;
    logic              sclk_q,     sclk_d;
    logic              data_out_q, data_out_d;
    logic              ldac_q,     ldac_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic              accept;
    logic              tick;
    logic              tick_en;

    assign tick_en = (state_q != ST_IDLE);

    clk_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        data_out_d = data_out_q;
        ldac_d     = ldac_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        accept     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_tx) begin
                    accept     = 1'b1;
                    shift_d    = build_frame(control, data_dac);
                    data_out_d = control[3];
                    cs_d       = 1'b0;
                    sclk_d     = 1'b0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    status_d   = STAT_SHIFT;
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        sclk_d   = 1'b0;
                        cs_d     = 1'b1;
                        status_d = STAT_SENT;
                        state_d  = ST_LATCH_LO;
                    end else begin
                        // Data only moves on the falling half so it is settled for the next rise;
                        // the MSB recirculates into the LSB, which is never transmitted.
                        sclk_d     = 1'b0;
                        shift_d    = {shift_q[FRAME_BITS-2:0], shift_q[FRAME_BITS-1]};
                        data_out_d = shift_q[FRAME_BITS-2];
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            ST_LATCH_LO: begin
                if (tick) begin
                    ldac_d  = 1'b0;
                    state_d = ST_LATCH_HI;
                end
            end

            ST_LATCH_HI: begin
                if (tick) begin
                    ldac_d   = 1'b1;
                    done_d   = 1'b1;
                    status_d = STAT_DONE;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d   = 1'b0;
                status_d = STAT_IDLE;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset is asynchronous so cs deasserts the instant a frame is aborted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            status_q   <= STAT_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            data_out_q <= 1'b0;
            ldac_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            data_out_q <= data_out_d;
            ldac_q     <= ldac_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign status   = status_q;
    assign cs       = cs_q;
    assign sclk     = sclk_q;
    assign data_out = data_out_q;
    assign ldac     = ldac_q;

endmodule

// File: tb/tb_dac_tx.sv
// Directed plus randomised bench for dac_tx: one instance at CLK_DIV=4, one at CLK_DIV=2.
module tb_dac_tx;

    localparam int DIV_A = 4;
    localparam int DIV_B = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  start_i;
    logic [3:0]  ctrl_i [2];
    logic [11:0] data_i [2];
    logic [1:0]  busy_o, done_o, cs_o, sclk_o, dout_o, ldac_o;
    logic [7:0]  status_o [2];

    int checks;
    int errors;
    int cyc;

    initial forever #5 clk = ~clk;
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    dac_tx #(.CLK_DIV(DIV_A)) u_dut_a (
        .clk(clk), .reset(rst_n), .start_tx(start_i[0]), .control(ctrl_i[0]), .data_dac(data_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .status(status_o[0]), .cs(cs_o[0]), .sclk(sclk_o[0]),
        .data_out(dout_o[0]), .ldac(ldac_o[0])
    );

    dac_tx #(.CLK_DIV(DIV_B)) u_dut_b (
        .clk(clk), .reset(rst_n), .start_tx(start_i[1]), .control(ctrl_i[1]), .data_dac(data_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .status(status_o[1]), .cs(cs_o[1]), .sclk(sclk_o[1]),
        .data_out(dout_o[1]), .ldac(ldac_o[1])
    );

    // Reference model: the wire frame is the command nibble followed by the sample, MSB first.
    function automatic logic [15:0] model_frame(input logic [3:0] c, input logic [11:0] d);
        logic [15:0] f;
        for (int b = 0; b < 4; b++)  f[15 - b] = c[3 - b];
        for (int b = 0; b < 12; b++) f[11 - b] = d[11 - b];
        return f;
    endfunction

    // Observer state, sampled on the falling clock edge.
    logic        pcs [2], psclk [2], pldac [2], act [2];
    logic [7:0]  pstat [2];
    logic [15:0] cap [2], last_frame [2];
    logic [15:0] flog [2][8];
    logic [39:0] trace [2];
    int run_cs [2], run_ld [2], bits [2], last_done [2];
    int nframes [2], done_cnt [2], ld_pulses [2], cs_len [2], ld_len [2], nbits [2];
    int spc_two [2], busy_bad [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            pcs[i] = 1'b1; psclk[i] = 1'b0; pldac[i] = 1'b1; act[i] = 1'b0; pstat[i] = 8'h00;
            cap[i] = '0; last_frame[i] = '0; trace[i] = '0;
            run_cs[i] = 0; run_ld[i] = 0; bits[i] = 0; last_done[i] = -1000;
            nframes[i] = 0; done_cnt[i] = 0; ld_pulses[i] = 0; cs_len[i] = 0; ld_len[i] = 0;
            nbits[i] = 0; spc_two[i] = 0; busy_bad[i] = 0;
            for (int k = 0; k < 8; k++) flog[i][k] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    act[i] = 1'b0;
                end else begin
                    if (pcs[i] && !cs_o[i]) begin
                        act[i] = 1'b1; cap[i] = '0; bits[i] = 0; run_cs[i] = 0;
                        if (cyc - last_done[i] == 2) spc_two[i]++;
                    end
                    if (!cs_o[i]) run_cs[i]++;
                    if (act[i] && !psclk[i] && sclk_o[i]) begin
                        cap[i] = {cap[i][14:0], dout_o[i]};
                        bits[i]++;
                    end
                    if (act[i] && !pcs[i] && cs_o[i]) begin
                        act[i] = 1'b0; cs_len[i] = run_cs[i]; nbits[i] = bits[i];
                        last_frame[i] = cap[i]; flog[i][nframes[i] % 8] = cap[i]; nframes[i]++;
                    end
                    if (busy_o[i] !== (status_o[i] != 8'h00)) busy_bad[i]++;
                end
                if (!ldac_o[i]) begin
                    if (pldac[i]) run_ld[i] = 0;
                    run_ld[i]++;
                end else if (!pldac[i]) begin
                    ld_len[i] = run_ld[i];
                    ld_pulses[i]++;
                end
                if (done_o[i]) begin
                    done_cnt[i]++;
                    last_done[i] = cyc;
                end
                if (status_o[i] !== pstat[i]) trace[i] = {trace[i][31:0], status_o[i]};
                pcs[i] = cs_o[i]; psclk[i] = sclk_o[i]; pldac[i] = ldac_o[i]; pstat[i] = status_o[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int idx, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt[idx] < target && n < budget) begin
            tick_clk();
            n++;
        end
        chk("wait_done", 40'(done_cnt[idx] >= target), 40'd1);
    endtask

    logic [3:0]  c, c2;
    logic [11:0] d, d2;
    logic [15:0] exp_f;
    int f0, dn0, lp0, s0;

    initial begin
        checks = 0; errors = 0;
        start_i = '0;
        ctrl_i[0] = '0; ctrl_i[1] = '0; data_i[0] = '0; data_i[1] = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick_clk();

        chk("rst_cs",     40'(cs_o[0]),     40'd1);
        chk("rst_sclk",   40'(sclk_o[0]),   40'd0);
        chk("rst_dout",   40'(dout_o[0]),   40'd0);
        chk("rst_ldac",   40'(ldac_o[0]),   40'd1);
        chk("rst_busy",   40'(busy_o[0]),   40'd0);
        chk("rst_done",   40'(done_o[0]),   40'd0);
        chk("rst_status", 40'(status_o[0]), 40'h00);
        chk("rst_cs_b",   40'(cs_o[1]),     40'd1);
        rst_n = 1'b1;
        repeat (2) tick_clk();

        // Single frame with the reference word.
        c = 4'hC; d = 12'hA5F;
        f0 = nframes[0]; dn0 = done_cnt[0]; lp0 = ld_pulses[0];
        ctrl_i[0] = c; data_i[0] = d; start_i[0] = 1'b1;
        tick_clk();
        start_i[0] = 1'b0;
        chk("acc_cs",     40'(cs_o[0]),     40'd0);
        chk("acc_busy",   40'(busy_o[0]),   40'd1);
        chk("acc_status", 40'(status_o[0]), 40'h02);
        chk("acc_dout",   40'(dout_o[0]),   40'(c[3]));
        wait_done(0, dn0 + 1, 400);
        repeat (5) tick_clk();
        chk("a_frame",   40'(last_frame[0]),      40'(16'b1100_1010_0101_1111));
        chk("a_model",   40'(last_frame[0]),      40'(model_frame(c, d)));
        chk("a_bits",    40'(nbits[0]),           40'd16);
        chk("a_cs_len",  40'(cs_len[0]),          40'(32 * DIV_A));
        chk("a_ld_len",  40'(ld_len[0]),          40'(DIV_A));
        chk("a_ld_cnt",  40'(ld_pulses[0] - lp0), 40'd1);
        chk("a_done",    40'(done_cnt[0] - dn0),  40'd1);
        chk("a_nframes", 40'(nframes[0] - f0),    40'd1);
        chk("a_trace",   trace[0],                40'h00_02_03_05_00);

        // Random frames with an ignored start and input churn mid-frame.
        for (int r = 0; r < 4; r++) begin
            c = 4'($urandom_range(0, 15)); d = 12'($urandom_range(0, 4095));
            exp_f = model_frame(c, d);
            f0 = nframes[0]; dn0 = done_cnt[0];
            ctrl_i[0] = c; data_i[0] = d; start_i[0] = 1'b1;
            tick_clk();
            start_i[0] = 1'b0;
            repeat ($urandom_range(3, 100)) tick_clk();
            ctrl_i[0] = 4'($urandom); data_i[0] = 12'($urandom); start_i[0] = 1'b1;
            tick_clk();
            start_i[0] = 1'b0;
            wait_done(0, dn0 + 1, 400);
            repeat (6) tick_clk();
            chk("rnd_frame", 40'(last_frame[0]),   40'(exp_f));
            chk("rnd_count", 40'(nframes[0] - f0), 40'd1);
            chk("rnd_idle",  40'(busy_o[0]),       40'd0);
        end

        // Start pulse at bit 7 with the sample cleared: frame unchanged, nothing queued.
        c = 4'h3; d = 12'h9C6;
        f0 = nframes[0]; dn0 = done_cnt[0];
        ctrl_i[0] = c; data_i[0] = d; start_i[0] = 1'b1;
        tick_clk();
        start_i[0] = 1'b0;
        for (int n = 0; n < 200 && bits[0] != 7; n++) tick_clk();
        chk("b7_reached", 40'(bits[0]), 40'd7);
        data_i[0] = 12'h000; start_i[0] = 1'b1;
        tick_clk();
        start_i[0] = 1'b0;
        wait_done(0, dn0 + 1, 400);
        repeat (200) tick_clk();
        chk("b7_frame", 40'(last_frame[0]),     40'(model_frame(c, d)));
        chk("b7_count", 40'(nframes[0] - f0),   40'd1);
        chk("b7_done",  40'(done_cnt[0] - dn0), 40'd1);

        // Reset at tick 20 aborts the frame; a new frame goes out on the first edge after release.
        c = 4'($urandom_range(0, 15)); d = 12'($urandom_range(0, 4095));
        dn0 = done_cnt[0]; lp0 = ld_pulses[0];
        ctrl_i[0] = c; data_i[0] = d; start_i[0] = 1'b1;
        tick_clk();
        start_i[0] = 1'b0;
        repeat (20 * DIV_A) tick_clk();
        chk("mid_cs",     40'(cs_o[0]),     40'd0);
        chk("mid_status", 40'(status_o[0]), 40'h02);
        rst_n = 1'b0;
        #1;
        chk("abort_cs",     40'(cs_o[0]),     40'd1);
        chk("abort_sclk",   40'(sclk_o[0]),   40'd0);
        chk("abort_ldac",   40'(ldac_o[0]),   40'd1);
        chk("abort_busy",   40'(busy_o[0]),   40'd0);
        chk("abort_status", 40'(status_o[0]), 40'h00);
        chk("abort_done",   40'(done_o[0]),   40'd0);
        c2 = 4'($urandom_range(0, 15)); d2 = 12'($urandom_range(0, 4095));
        ctrl_i[0] = c2; data_i[0] = d2; start_i[0] = 1'b1;
        repeat (2) tick_clk();
        rst_n = 1'b1;
        tick_clk();
        start_i[0] = 1'b0;
        chk("rel_cs",     40'(cs_o[0]),     40'd0);
        chk("rel_busy",   40'(busy_o[0]),   40'd1);
        chk("rel_status", 40'(status_o[0]), 40'h02);
        chk("rel_dout",   40'(dout_o[0]),   40'(c2[3]));
        wait_done(0, dn0 + 1, 400);
        repeat (5) tick_clk();
        chk("rel_frame", 40'(last_frame[0]),      40'(model_frame(c2, d2)));
        chk("rel_done",  40'(done_cnt[0] - dn0),  40'd1);
        chk("rel_ldac",  40'(ld_pulses[0] - lp0), 40'd1);

        // start_tx held high on the CLK_DIV=2 instance: three back-to-back frames.
        c = 4'($urandom_range(0, 15)); d = 12'($urandom_range(0, 4095));
        exp_f = model_frame(c, d);
        f0 = nframes[1]; dn0 = done_cnt[1]; s0 = spc_two[1];
        ctrl_i[1] = c; data_i[1] = d; start_i[1] = 1'b1;
        wait_done(1, dn0 + 3, 1000);
        start_i[1] = 1'b0;
        repeat (100) tick_clk();
        chk("bb_frames",  40'(nframes[1] - f0),  40'd3);
        chk("bb_done",    40'(done_cnt[1] - dn0), 40'd3);
        for (int k = 0; k < 3; k++) chk("bb_frame", 40'(flog[1][(f0 + k) % 8]), 40'(exp_f));
        chk("bb_spacing", 40'(spc_two[1] - s0),   40'd2);
        chk("bb_cs_len",  40'(cs_len[1]),         40'(32 * DIV_B));
        chk("bb_ld_len",  40'(ld_len[1]),         40'(DIV_B));

        chk("busy_vs_status_a", 40'(busy_bad[0]), 40'd0);
        chk("busy_vs_status_b", 40'(busy_bad[1]), 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_tx.md
DAC_TX -- requirements
Module: dac_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per serial tick; legal values are 2..65535.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_tx  input  1  request to send one frame; sampled only in IDLE.
REQ-005 control  input  4  DAC command nibble; becomes frame bits 15..12.
REQ-006 data_dac  input  12  DAC sample; becomes frame bits 11..0.
REQ-007 busy  output  1  high from the accept cycle until the cycle after done.
REQ-008 done  output  1  one-clk pulse when a frame has been sent and latched.
REQ-009 status  output  8  state code: 00 idle, 02 shifting, 03 frame sent/latching, 05 done.
REQ-010 cs  output  1  DAC chip select, active low.
REQ-011 sclk  output  1  serial clock to the DAC; the DAC samples data_out on sclk rising.
REQ-012 data_out  output  1  serial data, MSB first.
REQ-013 ldac  output  1  DAC load strobe, active low.

Function
REQ-014 The block SHALL generate the internal tick as a one-clk pulse when its divider reaches CLK_DIV-1.
- The divider SHALL clear on accept.
- The divider SHALL free-run only outside IDLE.
REQ-015 The state machine SHALL have the states IDLE, SHIFT, LATCH_LO, LATCH_HI and DONE.
REQ-016 IDLE: when start_tx=1, the block SHALL accept the request in the same cycle, with these effects at the next edge:
- shift register <= {control, data_dac}
- data_out <= control[3]; cs <= 0; sclk <= 0; bit counter <= 0
- busy <= 1; status <= 02; state <= SHIFT
REQ-017 SHIFT, on each tick:
- if sclk=0: sclk <= 1.
- else if bit counter=15: sclk <= 0, cs <= 1, status <= 03, state <= LATCH_LO.
- else: sclk <= 0, shift left, data_out <= next bit, bit counter increments.
REQ-018 cs SHALL stay low for exactly 32 ticks (32*CLK_DIV clk cycles), and the frame SHALL carry exactly 16 sclk rising edges.
REQ-019 data_out SHALL change only while sclk is low or in the accept cycle, so it is never unstable on an sclk rising edge.
REQ-020 LATCH_LO SHALL drive ldac <= 0 on the next tick and go to LATCH_HI.
REQ-021 LATCH_HI SHALL drive ldac <= 1 on the next tick and go to DONE, so ldac is low for exactly one tick.
REQ-022 DONE SHALL last one clk, with done=1 and status=05, and then go to IDLE with busy <= 0 and status <= 00.
REQ-023 The earliest next accept SHALL be the cycle after DONE.
REQ-024 start_tx asserted while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-025 control and data_dac SHALL be sampled only at accept; changes during a frame SHALL have no effect.
REQ-026 start_tx held high continuously SHALL produce back-to-back frames, separated by the DONE cycle plus the accept.

Reset
REQ-027 While reset=0, the block SHALL hold:
- cs=1, sclk=0, data_out=0, ldac=1
- busy=0, done=0, status=00
- state IDLE; divider, bit counter and shift register all 0
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with cs rising asynchronously; no ldac pulse and no done SHALL be issued.
REQ-029 After reset deasserts, the first accept SHALL be possible on the first clk edge.

Structure
REQ-030 A shared package SHALL hold:
- state encodings
- status codes (00, 02, 03, 05)
- the FRAME_BITS=16 constant
REQ-031 The tick divider SHALL be a separate sub-module, clk_tick_div, parameterised by CLK_DIV, with ports clk, reset, clr, en, tick.
- The same divider is intended for reuse by the ADC-side sampler.

Verification
REQ-032 CLK_DIV=4, control=4'hC, data_dac=12'hA5F, one start_tx pulse -> the bench SHALL require:
- serial bits 1100_1010_0101_1111 captured on sclk rising
- cs low for 128 clk
- ldac low for 4 clk
- one done pulse
REQ-033 CLK_DIV=2, start_tx held high for 3 frames -> the bench SHALL require 3 identical frames and 3 done pulses, with exactly 2 clk of IDLE-to-next-cs-low spacing after each done.
REQ-034 start_tx pulsed at bit 7 of a frame in progress, with data_dac changed to 12'h000 -> the bench SHALL require the current frame unchanged and no extra frame.
REQ-035 reset asserted at tick 20 of a frame -> the bench SHALL require:
- cs=1, sclk=0, ldac=1, busy=0, status=00 within the same cycle
- no done pulse
- a new frame accepted on the first edge after release
REQ-036 Status trace for a single frame -> the bench SHALL require the sequence 00, 02, 03, 05, 00, with busy=1 exactly from accept through DONE.
